// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the central stall/flush controller.
//
// Pipeline-side observations (driven by the master/datapath):
//   id_rs1, id_rs2        [4:0]  source registers of the instruction in ID
//   id_use_rs1, id_use_rs2       ID instruction actually reads rs1 / rs2
//   ex_rd                 [4:0]  destination register of the instruction in EX
//   ex_mem_read                  EX instruction is a load
//   ex_md_start                  EX holds a mul/div op (level)
//   ex_br_taken                  branch/jump taken, resolved in EX
//   mem_req                      MEM stage accesses data memory (level)
//   mem_ack                      data memory completes the access this cycle
// Controller outputs (driven by the slave/controller):
//   stall_if/id/ex/mem           hold PC, IF/ID, ID/EX, EX/MEM
//   flush_id/ex/mem/wb           load NOP into IF/ID, ID/EX, EX/MEM, MEM/WB
//   md_go                        one-cycle start pulse to the mul/div unit
//   bus_err                      data-memory timeout, one cycle
//   stall_cycles          [31:0] saturating count of cycles with stall_if=1
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_md_start;
    logic        ex_br_taken;
    logic        mem_req;
    logic        mem_ack;

    logic        stall_if;
    logic        stall_id;
    logic        stall_ex;
    logic        stall_mem;
    logic        flush_id;
    logic        flush_ex;
    logic        flush_mem;
    logic        flush_wb;
    logic        md_go;
    logic        bus_err;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_md_start, ex_br_taken, mem_req, mem_ack,
        input  stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, flush_mem, flush_wb,
               md_go, bus_err, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_md_start, ex_br_taken, mem_req, mem_ack,
        output stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, flush_mem, flush_wb,
               md_go, bus_err, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for a 5-stage pipeline. Resolves, in strict
// priority order: data-memory wait states (with a timeout watchdog), mul/div
// occupancy of EX, taken branches resolved in EX, and load-use hazards.
// Also keeps a saturating count of cycles in which the PC is held.
//
// Parameters:
//   MD_LATENCY    cycles the mul/div unit occupies EX (>= 1)
//   DMEM_TIMEOUT  stalled cycles allowed waiting for mem_ack before abort (>= 1)
// Ports:
//   clk    pipeline clock
//   rst_n  asynchronous active-low reset
//   hz     controller side (slave modport) of pipe_hazard_ctrl_if
//
// Stall/flush/md_go/bus_err are combinational from state and inputs because
// the pipeline registers must see them in the same cycle the hazard exists.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY   = 4,
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int WCNT_W = $clog2(DMEM_TIMEOUT + 1);
    localparam int DCNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

    localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(DMEM_TIMEOUT);
    localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(MD_LATENCY - 1);
    localparam logic [31:0]       CNT_SAT   = 32'hFFFF_FFFF;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_BUSY = 1'b1
    } md_state_t;

    mem_state_t        mem_state_r;
    md_state_t         md_state_r;
    logic [WCNT_W-1:0] wcnt_r;
    logic [DCNT_W-1:0] dcnt_r;
    logic [31:0]       stall_cycles_r;

    logic timeout_s;
    logic memstall_s;
    logic md_go_s;
    logic mdstall_s;
    logic branch_s;
    logic raw_hazard_s;
    logic loaduse_s;
    logic stall_if_s;

    // Hazard event decode with priority timeout/memstall > mdstall > branch > loaduse.
    always_comb begin
        timeout_s    = 1'b0;
        memstall_s   = 1'b0;
        md_go_s      = 1'b0;
        mdstall_s    = 1'b0;
        branch_s     = 1'b0;
        raw_hazard_s = 1'b0;
        loaduse_s    = 1'b0;

        timeout_s  = (mem_state_r == M_WAIT) && (wcnt_r == WCNT_MAX);
        memstall_s = hz.mem_req && !hz.mem_ack && !timeout_s;

        // A mul/div request arriving under a memory stall waits; memstall
        // already freezes EX, so the op is simply launched later.
        md_go_s   = hz.ex_md_start && (md_state_r == D_IDLE) && !memstall_s;
        mdstall_s = (md_go_s || ((md_state_r == D_BUSY) && (dcnt_r != DCNT_ZERO)))
                    && !memstall_s;

        // A taken branch squashes the ID instruction, so it also wins over loaduse.
        branch_s = hz.ex_br_taken && !memstall_s && !mdstall_s;

        // x0 is hardwired to zero and never creates a dependency.
        raw_hazard_s = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                       ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                        (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
        loaduse_s    = raw_hazard_s && !memstall_s && !mdstall_s && !branch_s;

        stall_if_s = memstall_s || mdstall_s || loaduse_s;
    end

    // Map hazard events onto per-stage hold and bubble-insert controls.
    always_comb begin
        hz.stall_if  = 1'b0;
        hz.stall_id  = 1'b0;
        hz.stall_ex  = 1'b0;
        hz.stall_mem = 1'b0;
        hz.flush_id  = 1'b0;
        hz.flush_ex  = 1'b0;
        hz.flush_mem = 1'b0;
        hz.flush_wb  = 1'b0;
        hz.md_go     = 1'b0;
        hz.bus_err   = 1'b0;

        hz.stall_if  = stall_if_s;
        hz.stall_id  = stall_if_s;
        hz.stall_ex  = memstall_s || mdstall_s;
        hz.stall_mem = memstall_s;
        hz.flush_id  = branch_s;
        hz.flush_ex  = branch_s || loaduse_s;
        hz.flush_mem = mdstall_s;
        // On timeout the faulting MEM instruction is dropped instead of retired.
        hz.flush_wb  = memstall_s || timeout_s;
        hz.md_go     = md_go_s;
        hz.bus_err   = timeout_s;
    end

    assign hz.stall_cycles = stall_cycles_r;

    // Data-memory wait FSM: wcnt counts stalled cycles of the current access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_state_r <= M_IDLE;
            wcnt_r      <= WCNT_ZERO;
        end else begin
            case (mem_state_r)
                M_IDLE: begin
                    if (memstall_s) begin
                        mem_state_r <= M_WAIT;
                        wcnt_r      <= WCNT_ONE;
                    end else begin
                        mem_state_r <= M_IDLE;
                        wcnt_r      <= WCNT_ZERO;
                    end
                end
                M_WAIT: begin
                    // memstall drops on ack, on timeout, or if the request vanishes.
                    if (memstall_s) begin
                        mem_state_r <= M_WAIT;
                        wcnt_r      <= wcnt_r + WCNT_ONE;
                    end else begin
                        mem_state_r <= M_IDLE;
                        wcnt_r      <= WCNT_ZERO;
                    end
                end
                default: begin
                    mem_state_r <= M_IDLE;
                    wcnt_r      <= WCNT_ZERO;
                end
            endcase
        end
    end

    // Mul/div occupancy FSM: dcnt counts down the remaining busy cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state_r <= D_IDLE;
            dcnt_r     <= DCNT_ZERO;
        end else begin
            case (md_state_r)
                D_IDLE: begin
                    if (md_go_s) begin
                        md_state_r <= D_BUSY;
                        dcnt_r     <= DCNT_LOAD;
                    end else begin
                        md_state_r <= D_IDLE;
                        dcnt_r     <= DCNT_ZERO;
                    end
                end
                D_BUSY: begin
                    // The unit keeps computing during a memory stall, but EX
                    // may only be released once MEM can accept the result.
                    if (dcnt_r != DCNT_ZERO) begin
                        md_state_r <= D_BUSY;
                        dcnt_r     <= dcnt_r - DCNT_ONE;
                    end else if (!memstall_s) begin
                        md_state_r <= D_IDLE;
                        dcnt_r     <= DCNT_ZERO;
                    end else begin
                        md_state_r <= D_BUSY;
                        dcnt_r     <= DCNT_ZERO;
                    end
                end
                default: begin
                    md_state_r <= D_IDLE;
                    dcnt_r     <= DCNT_ZERO;
                end
            endcase
        end
    end

    // Saturating performance counter of front-end stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= 32'd0;
        end else if (stall_if_s && (stall_cycles_r != CNT_SAT)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// protocol-respecting random stimulus, all compared every cycle against a
// behavioural model that tracks "cycles waited on memory" and "age of the
// mul/div op" rather than the controller's state encoding.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT = 4;
    localparam int DTO    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(
        .MD_LATENCY   (MD_LAT),
        .DMEM_TIMEOUT (DTO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int     m_waited = 0;     // stalled cycles spent on the current memory access
    int     m_age    = -1;    // cycles since md_go; -1 when no mul/div op is in EX
    longint m_cnt    = 0;     // stall_if cycles, unsaturated
    logic [9:0] last_obs;
    bit     last_timeout;
    bit     last_md_release;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Order: stall_if stall_id stall_ex stall_mem flush_id flush_ex flush_mem flush_wb md_go bus_err
    function automatic logic [9:0] obs_vec();
        return {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                hz.flush_id, hz.flush_ex, hz.flush_mem, hz.flush_wb,
                hz.md_go, hz.bus_err};
    endfunction

    task automatic set_idle();
        hz.id_rs1      = 5'd0;
        hz.id_rs2      = 5'd0;
        hz.id_use_rs1  = 1'b0;
        hz.id_use_rs2  = 1'b0;
        hz.ex_rd       = 5'd0;
        hz.ex_mem_read = 1'b0;
        hz.ex_md_start = 1'b0;
        hz.ex_br_taken = 1'b0;
        hz.mem_req     = 1'b0;
        hz.mem_ack     = 1'b0;
    endtask

    task automatic model_reset();
        m_waited = 0;
        m_age    = -1;
        m_cnt    = 0;
    endtask

    // Evaluate one cycle with the inputs currently applied, compare, then step the model.
    task automatic cycle(input string tag);
        bit to, ms, busy, go, mds, br, hzd, lu;
        logic [9:0] exp;
        to   = (m_waited == DTO);
        ms   = hz.mem_req && !hz.mem_ack && !to;
        busy = (m_age >= 0);
        go   = hz.ex_md_start && !busy && !ms;
        mds  = (go || (busy && m_age < MD_LAT)) && !ms;
        br   = hz.ex_br_taken && !ms && !mds;
        hzd  = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
        lu   = hzd && !ms && !mds && !br;
        exp  = {ms | mds | lu, ms | mds | lu, ms | mds, ms,
                br, br | lu, mds, ms | to, go, to};
        #1;
        last_obs = obs_vec();
        check_val({tag, "_outs"}, 32'(last_obs), 32'(exp));
        check_val({tag, "_cnt"}, hz.stall_cycles, m_cnt[31:0]);
        if (exp[9] && m_cnt < 64'sh0000_0000_FFFF_FFFF) m_cnt++;
        m_waited        = ms ? m_waited + 1 : 0;
        last_timeout    = to;
        last_md_release = 1'b0;
        if (go) begin
            m_age = 1;
        end else if (busy) begin
            if (m_age >= MD_LAT && !ms) begin
                m_age = -1;
                last_md_release = 1'b1;
            end else begin
                m_age++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n_go, n_stall, n;
        bit  seen, in_acc, acc_noack, md_hold;
        longint cnt0;

        set_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_outs", 32'(obs_vec()), 32'd0);
        check_val("rst_cnt", hz.stall_cycles, 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Load-use: one bubble, and none for x0
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_use_rs1 = 1'b1;
        cycle("lu");
        check_val("lu_vec", 32'(last_obs), 32'(10'b1100010000));
        hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0;
        cycle("lu_x0");
        check_val("lu_x0_vec", 32'(last_obs), 32'd0);
        set_idle();
        cycle("lu_after");

        // Branch vs load-use, then with memstall on top
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd3; hz.id_rs2 = 5'd3; hz.id_use_rs2 = 1'b1;
        hz.ex_br_taken = 1'b1;
        cycle("br_lu");
        check_val("br_lu_vec", 32'(last_obs), 32'(10'b0000110000));
        hz.mem_req = 1'b1;
        cycle("br_mem");
        check_val("br_mem_vec", 32'(last_obs), 32'(10'b1111000100));
        hz.mem_ack = 1'b1;
        cycle("br_ack");
        set_idle();
        cycle("br_idle");

        // Mul/div occupancy
        cnt0 = m_cnt;
        hz.ex_md_start = 1'b1;
        n_go = 0; n_stall = 0;
        for (int i = 0; i < 5; i++) begin
            cycle("md");
            n_go    += int'(last_obs[1]);
            n_stall += int'(last_obs[7] & last_obs[3]);
        end
        check_val("md_release", 32'(last_obs), 32'd0);
        check_val("md_go_n", 32'(n_go), 32'd1);
        check_val("md_stall_n", 32'(n_stall), 32'(MD_LAT));
        check_val("md_cnt", hz.stall_cycles, 32'(cnt0 + MD_LAT));
        hz.ex_md_start = 1'b0;
        cycle("md_idle");

        // Memory wait with ack on the third cycle
        hz.mem_req = 1'b1;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            cycle("mw");
            n += int'(last_obs[6] & last_obs[2]);
        end
        hz.mem_ack = 1'b1;
        cycle("mw_ack");
        check_val("mw_stall_n", 32'(n), 32'd2);
        check_val("mw_ack_vec", 32'(last_obs), 32'd0);
        set_idle();
        cycle("mw_idle");

        // Timeout: DTO stall cycles then one bus_err release cycle
        hz.mem_req = 1'b1;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle("to");
            if (last_obs[0]) seen = 1'b1;
            else if (last_obs[6]) n++;
        end
        check_val("to_seen", 32'(seen), 32'd1);
        check_val("to_stall_n", 32'(n), 32'(DTO));
        check_val("to_vec", 32'(last_obs), 32'(10'b0000000101));
        cycle("to_restart");
        check_val("to_restart_stall", 32'(last_obs[6]), 32'd1);
        hz.mem_ack = 1'b1;
        cycle("to_ack");
        set_idle();
        cycle("to_idle");

        // Reset during a mul/div stall
        hz.ex_md_start = 1'b1;
        cycle("mr");
        #1 rst_n = 1'b0;
        #1;
        check_val("mr_rst_cnt", hz.stall_cycles, 32'd0);
        check_val("mr_rst_mem", 32'({hz.stall_mem, hz.flush_wb, hz.bus_err}), 32'd0);
        #1 rst_n = 1'b1;
        model_reset();
        cycle("mr_fresh");
        check_val("mr_fresh_go", 32'(last_obs[1]), 32'd1);
        for (int i = 0; i < MD_LAT; i++) cycle("mr_run");
        set_idle();
        cycle("mr_idle");

        // Random, protocol-respecting traffic
        in_acc = 1'b0; acc_noack = 1'b0; md_hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!in_acc && $urandom_range(0, 3) == 0) begin
                in_acc    = 1'b1;
                acc_noack = ($urandom_range(0, 7) == 0);
            end
            hz.mem_req = in_acc;
            hz.mem_ack = in_acc && !acc_noack && ($urandom_range(0, 2) == 0);
            if (!md_hold && $urandom_range(0, 5) == 0) md_hold = 1'b1;
            hz.ex_md_start = md_hold;
            hz.ex_br_taken = ($urandom_range(0, 5) == 0);
            hz.ex_mem_read = 1'($urandom_range(0, 1));
            hz.ex_rd       = 5'($urandom_range(0, 3));
            hz.id_rs1      = 5'($urandom_range(0, 3));
            hz.id_rs2      = 5'($urandom_range(0, 3));
            hz.id_use_rs1  = 1'($urandom_range(0, 1));
            hz.id_use_rs2  = 1'($urandom_range(0, 1));
            cycle("rnd");
            if (hz.mem_ack || last_timeout) in_acc = 1'b0;
            if (last_md_release) md_hold = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
